// File: rtl/mem_stage_access_ctrl_pkg.sv
// Shared types and constants for the memory-stage access controller.
// The FSM encoding and the load result-select code live here.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } memState_t;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  localparam int XLEN_DEF           = 32;
  localparam int CNT_W_DEF          = 32;
  localparam int TIMEOUT_CYCLES_DEF = 255;

endpackage

// File: rtl/mem_stage_access_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear, clocked on the falling edge
// so it updates together with the pipeline registers.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, holding at all-ones instead of wrapping; clear wins.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/mem_stage_access_ctrl.sv
// Memory-stage sequencer: drives the data-memory req/ack handshake and
// stalls the pipeline while an access is outstanding. Optional timeout/error
// support is enabled with the MEM_TIMEOUT_EN macro.
module mem_stage_access_ctrl
  import mem_stage_pkg::*;
#(
  parameter int XLEN           = XLEN_DEF,
  parameter int CNT_W          = CNT_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWriteM,
  input  logic             MemWriteM,
  input  logic [1:0]       ResultSrcM,
  input  logic [XLEN-1:0]  ALUResultM,
  input  logic [XLEN-1:0]  WriteDataM,
  output logic             mem_req,
  output logic             mem_we,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  input  logic             mem_ack,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             StallPipe,
  output logic [XLEN-1:0]  ReadDataM,
  output logic             RegWriteMq,
`ifdef MEM_TIMEOUT_EN
  output logic             mem_err,
`endif
  output logic [CNT_W-1:0] stall_cnt
);

  memState_t       state;
  logic            isLoad;
  logic            access;
  logic            ackLoad;
  logic [XLEN-1:0] loadData;

  assign isLoad  = (ResultSrcM == RESULT_SRC_LOAD);
  assign access  = MemWriteM | isLoad;
  // An ack seen after a timeout belongs to an abandoned request.
  assign ackLoad = isLoad & mem_ack & (state != ERR);

  // Address and data come straight from M; they are stable while M is frozen.
  assign mem_we    = MemWriteM;
  assign mem_addr  = ALUResultM;
  assign mem_wdata = WriteDataM;

  // Request and stall generation from the current handshake state.
  always_comb begin
    mem_req   = 1'b0;
    StallPipe = 1'b0;
    case (state)
      IDLE: begin
        mem_req   = access;
        StallPipe = access & ~mem_ack;
      end
      WAIT: begin
        mem_req   = 1'b1;
        StallPipe = access & ~mem_ack;
      end
      ERR: begin
        mem_req   = 1'b0;
        StallPipe = 1'b1;
      end
      default: begin
        mem_req   = 1'b0;
        StallPipe = 1'b0;
      end
    endcase
  end

  assign RegWriteMq = RegWriteM & ~StallPipe;

  // Forward load data in its ack cycle, otherwise replay the last capture.
  always_comb begin
    if (ackLoad) begin
      ReadDataM = mem_rdata;
    end else begin
      ReadDataM = loadData;
    end
  end

  // Capture each completed load so ReadDataM stays valid after the ack.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      loadData <= '0;
    end else if (ackLoad) begin
      loadData <= mem_rdata;
    end
  end

  sat_counter #(.W(CNT_W)) u_stallCnt (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .inc   (StallPipe),
    .count (stall_cnt)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] waitCnt;
  logic          timedOut;

  // Held clear outside WAIT, so it reads zero on the first WAIT cycle.
  sat_counter #(.W(TW)) u_waitCnt (
    .clk   (clk),
    .reset (reset),
    .clear (state != WAIT),
    .inc   (state == WAIT),
    .count (waitCnt)
  );

  assign timedOut = (state == WAIT) && (waitCnt == TW'(TIMEOUT_CYCLES - 1));
`endif

  // Handshake FSM; ERR is terminal until reset.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
`ifdef MEM_TIMEOUT_EN
      mem_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (access && !mem_ack) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            state <= IDLE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (timedOut) begin
            state   <= ERR;
            mem_err <= 1'b1;
          end
`endif
        end
        ERR: begin
          state <= ERR;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
